// File: rtl/layer_ctrl_pkg.sv
// Shared definitions for the layer sequencers.
//   state_e    : sequencer FSM encodings
//   ROW_PERIOD : unstalled row period for the default configuration
//   row_period : unstalled row period for an arbitrary K / RD_LAT
package layer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FETCH   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_ROW_END = 3'd4
  } state_e;

  localparam int K_DEF      = 8;
  localparam int RD_LAT_DEF = 1;
  // CLEAR + K issues + RD_LAT drain cycles + ROW_END
  localparam int ROW_PERIOD = K_DEF + RD_LAT_DEF + 2;

  function automatic int row_period(input int k, input int rd_lat);
    return k + rd_lat + 2;
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid-flag delay line matching the BRAM read latency.
//   clk_i, rstn_i : clock, async active-low reset
//   adv_i         : shift enable (low = frozen, used for backpressure)
//   in_i          : issue flag entering the head
//   tail_o        : flag leaving after DEPTH advances
module rd_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic adv_i,
  input  logic in_i,
  output logic tail_o
);

  logic [DEPTH-1:0] vld_pipe_q, vld_pipe_d;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (adv_i) begin
      vld_pipe_d[0] = in_i;
      for (int i = 1; i < DEPTH; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) vld_pipe_q <= '0;
    else         vld_pipe_q <= vld_pipe_d;
  end

  assign tail_o = vld_pipe_q[DEPTH-1];

endmodule

// File: rtl/layer_seq_ctrl.sv
// Fully-connected layer sequencer: per input row, clear the PU, stream K
// weights against the held input word, absorb BRAM read latency, then pulse
// the next-layer enable. Downstream stall freezes issue and the valid pipe.
//   clk_i, rstn_i            : clock, async active-low reset
//   start_i                  : run request (sampled in IDLE only)
//   stall_i                  : downstream backpressure
//   din1_addr_o / din1_en_o  : input BRAM row address / enable
//   din2_addr_o / din2_en_o  : weight BRAM address (r*K+k) / enable
//   ram_regce_o              : BRAM output register enable (~stall_i)
//   pu_en_o, pu_valid_o, pu_clear_o : PU enable, operand valid, acc clear
//   pu2_en_o                 : row result complete pulse
//   busy_o, done_o           : run in progress / final row complete pulse
module layer_seq_ctrl
  import layer_ctrl_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int K       = 8,
  parameter int DADDR_W = 2,
  parameter int WADDR_W = 5,
  parameter int RD_LAT  = 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               stall_i,
  output logic [DADDR_W-1:0] din1_addr_o,
  output logic               din1_en_o,
  output logic [WADDR_W-1:0] din2_addr_o,
  output logic               din2_en_o,
  output logic               ram_regce_o,
  output logic               pu_en_o,
  output logic               pu_valid_o,
  output logic               pu_clear_o,
  output logic               pu2_en_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;

  state_e             state_q, state_d;
  logic [DADDR_W-1:0] r_q, r_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;   // running r*K+k, no multiplier
  logic [1:0]         dcnt_q, dcnt_d;     // unstalled DRAIN cycles seen
  logic               issue;
  logic               tail;

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    k_d        = k_q;
    waddr_d    = waddr_q;
    dcnt_d     = dcnt_q;
    issue      = 1'b0;
    pu_en_o    = 1'b0;
    pu_clear_o = 1'b0;
    pu2_en_o   = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CLEAR;
          r_d     = '0;
          waddr_d = '0;
        end
      end
      ST_CLEAR: begin
        // clear is not held off by stall: nothing downstream consumes it
        pu_en_o    = 1'b1;
        pu_clear_o = 1'b1;
        k_d        = '0;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        pu_en_o = 1'b1;
        if (!stall_i) begin
          issue   = 1'b1;
          waddr_d = waddr_q + WADDR_W'(1);
          if (k_q == KW'(K - 1)) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // the last issue reaches the tail after RD_LAT unstalled cycles
        pu_en_o = 1'b1;
        if (!stall_i) begin
          if (dcnt_q == 2'(RD_LAT - 1)) state_d = ST_ROW_END;
          else                          dcnt_d  = dcnt_q + 2'd1;
        end
      end
      ST_ROW_END: begin
        pu2_en_o = 1'b1;
        if (r_q == DADDR_W'(ROWS - 1)) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          r_d     = r_q + DADDR_W'(1);
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      k_q     <= '0;
      waddr_q <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      waddr_q <= waddr_d;
      dcnt_q  <= dcnt_d;
    end
  end

  rd_lat_pipe #(.DEPTH(RD_LAT)) u_vld_pipe (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .adv_i  (~stall_i),
    .in_i   (issue),
    .tail_o (tail)
  );

  assign din1_en_o   = issue;
  assign din2_en_o   = issue;
  assign din1_addr_o = r_q;
  assign din2_addr_o = waddr_q;
  assign ram_regce_o = ~stall_i;
  // a stalled tail is held and presented again once stall drops
  assign pu_valid_o  = tail & ~stall_i;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench: dut_a uses defaults (RD_LAT=1) and drives a BRAM + MAC
// model; dut_b uses RD_LAT=2 and is checked for valid timing only.
module tb_layer_seq_ctrl;
  localparam int NCAP = 64;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, stall = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] a_d1a, b_d1a;
  logic [4:0] a_d2a, b_d2a;
  logic a_d1e, a_d2e, a_rce, a_pen, a_vld, a_clr, a_p2, a_busy, a_done;
  logic b_d1e, b_d2e, b_rce, b_pen, b_vld, b_clr, b_p2, b_busy, b_done;

  layer_seq_ctrl dut_a (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .stall_i(stall),
    .din1_addr_o(a_d1a), .din1_en_o(a_d1e), .din2_addr_o(a_d2a), .din2_en_o(a_d2e),
    .ram_regce_o(a_rce), .pu_en_o(a_pen), .pu_valid_o(a_vld), .pu_clear_o(a_clr),
    .pu2_en_o(a_p2), .busy_o(a_busy), .done_o(a_done));

  layer_seq_ctrl #(.RD_LAT(2)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .stall_i(stall),
    .din1_addr_o(b_d1a), .din1_en_o(b_d1e), .din2_addr_o(b_d2a), .din2_en_o(b_d2e),
    .ram_regce_o(b_rce), .pu_en_o(b_pen), .pu_valid_o(b_vld), .pu_clear_o(b_clr),
    .pu2_en_o(b_p2), .busy_o(b_busy), .done_o(b_done));

  int tests = 0, fails = 0;

  // BRAM model (RD_LAT=1, no-change: output holds when not enabled)
  logic [63:0] mem1 [4];
  logic [7:0]  mem2 [32];
  logic [63:0] dout1 = '0;
  logic [7:0]  dout2 = '0;
  always @(posedge clk) begin
    if (a_d1e) dout1 <= mem1[a_d1a];
    if (a_d2e) dout2 <= mem2[a_d2a];
  end

  int acc [8];
  int res [$];
  int en_mis;

  logic [NCAP-1:0] cap_clr, cap_vld, cap_p2, cap_dn, cap_busy, cap_en, cap_rce;
  logic [NCAP-1:0] bc_vld, bc_p2, bc_dn, bc_rce;
  int cap_addr [NCAP];

  typedef struct {
    int cyc;
    bit clr, vld, p2, dn, busy, en;
    int addr;                 // -1: not checked
  } vec_t;
  vec_t tab [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pmask(input int first, input int len, input int period, input int n);
    logic [63:0] m = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < len; j++) m[first + i*period + j] = 1'b1;
    return m;
  endfunction

  task automatic sample(input int c);
    cap_clr[c] = a_clr; cap_vld[c] = a_vld; cap_p2[c] = a_p2; cap_dn[c] = a_done;
    cap_busy[c] = a_busy; cap_en[c] = a_d2e; cap_rce[c] = a_rce; cap_addr[c] = int'(a_d2a);
    bc_vld[c] = b_vld; bc_p2[c] = b_p2; bc_dn[c] = b_done; bc_rce[c] = b_rce;
    if (a_d1e !== a_d2e) en_mis++;
    if (a_clr) for (int l = 0; l < 8; l++) acc[l] = 0;
    if (a_vld) for (int l = 0; l < 8; l++) acc[l] += int'(dout1[8*l +: 8]) * int'(dout2);
    if (a_p2)  for (int l = 0; l < 8; l++) res.push_back(acc[l]);
  endtask

  task automatic do_reset();
    start = 1'b0; stall = 1'b0; rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // cycle 0 is the cycle whose closing edge samples start; cycle c is sampled
  // 2 time units after the edge that opens it
  task automatic run_cap(input int ncyc, input int s_lo, input int s_hi,
                         input bit hold, input int pulse_at, input int rst_at);
    cap_clr = '0; cap_vld = '0; cap_p2 = '0; cap_dn = '0; cap_busy = '0;
    cap_en = '0; cap_rce = '0; bc_vld = '0; bc_p2 = '0; bc_dn = '0; bc_rce = '0;
    for (int i = 0; i < NCAP; i++) cap_addr[i] = 0;
    for (int l = 0; l < 8; l++) acc[l] = 0;
    res.delete(); en_mis = 0;
    @(negedge clk);
    start = 1'b1;
    #1 sample(0);
    for (int c = 1; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      start = hold || (c == pulse_at);
      stall = (c >= s_lo) && (c <= s_hi);
      #1 sample(c);
      if (c == rst_at) begin
        chk("pre_rst_en", a_d1e, 1);
        #1 rstn = 1'b0;
        #1 chk("rst_async_outs",
               {a_d1a, a_d1e, a_d2a, a_d2e, a_pen, a_vld, a_clr, a_p2, a_busy, a_done}, 0);
      end
    end
    start = 1'b0; stall = 1'b0;
  endtask

  task automatic check_tab(input string tag);
    foreach (tab[i]) begin
      int c;
      c = tab[i].cyc;
      chk($sformatf("%s c%0d flags{clr,vld,p2,dn,busy,en}", tag, c),
          {cap_clr[c], cap_vld[c], cap_p2[c], cap_dn[c], cap_busy[c], cap_en[c]},
          {tab[i].clr, tab[i].vld, tab[i].p2, tab[i].dn, tab[i].busy, tab[i].en});
      if (tab[i].addr >= 0)
        chk($sformatf("%s c%0d din2_addr", tag, c), cap_addr[c], tab[i].addr);
    end
  endtask

  task automatic check_nominal(input string tag);
    int n, bad, gold;
    tab.delete();
    tab.push_back('{0, 0,0,0,0,0,0, 0});
    tab.push_back('{1, 1,0,0,0,1,0, 0});
    tab.push_back('{2, 0,0,0,0,1,1, 0});
    tab.push_back('{3, 0,1,0,0,1,1, 1});
    tab.push_back('{9, 0,1,0,0,1,1, 7});
    tab.push_back('{10,0,1,0,0,1,0, 8});
    tab.push_back('{11,0,0,1,0,1,0, 8});
    tab.push_back('{12,1,0,0,0,1,0, 8});
    tab.push_back('{13,0,0,0,0,1,1, 8});
    tab.push_back('{44,0,0,1,1,1,0, 0});
    tab.push_back('{45,0,0,0,0,0,0, 0});
    check_tab(tag);
    chk({tag, " clr_mask"},  cap_clr,  pmask(1, 1, 11, 4));
    chk({tag, " en_mask"},   cap_en,   pmask(2, 8, 11, 4));
    chk({tag, " vld_mask"},  cap_vld,  pmask(3, 8, 11, 4));
    chk({tag, " p2_mask"},   cap_p2,   pmask(11, 1, 11, 4));
    chk({tag, " done_mask"}, cap_dn,   pmask(44, 1, 1, 1));
    chk({tag, " busy_mask"}, cap_busy, pmask(1, 44, 1, 1));
    chk({tag, " en1_en2_mismatch_cycles"}, en_mis, 0);
    n = 0; bad = 0;
    for (int c = 0; c < NCAP; c++)
      if (cap_en[c]) begin
        if (cap_addr[c] != n) bad++;
        n++;
      end
    chk({tag, " addr_seq_bad"}, bad, 0);
    chk({tag, " result_count"}, res.size(), 32);
    if (res.size() == 32)
      for (int r = 0; r < 4; r++)
        for (int l = 0; l < 8; l++) begin
          gold = 0;
          for (int k = 0; k < 8; k++)
            gold += int'(mem1[r][8*l +: 8]) * int'(mem2[r*8 + k]);
          chk($sformatf("%s row%0d lane%0d sum", tag, r, l), res[r*8 + l], gold);
        end
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int l = 0; l < 8; l++) mem1[i][8*l +: 8] = 8'(i*16 + l*3 + 1);
    for (int j = 0; j < 32; j++) mem2[j] = 8'(j*7 + 3);

    // reset state
    do_reset();
    chk("rst_outs_a", {a_d1a, a_d1e, a_d2a, a_d2e, a_pen, a_vld, a_clr, a_p2, a_busy, a_done}, 0);
    chk("rst_busy_b", b_busy, 0);
    chk("rst_regce", {a_rce, b_rce}, 2'b11);

    // nominal, with a stray start pulse mid-run
    run_cap(NCAP, 100, 99, 1'b0, 20, -1);
    check_nominal("nom");

    // stall in row 0 FETCH, cycles 5..7
    do_reset();
    run_cap(NCAP, 5, 7, 1'b0, -1, -1);
    tab.delete();
    tab.push_back('{4, 0,1,0,0,1,1, 2});
    tab.push_back('{5, 0,0,0,0,1,0, 3});
    tab.push_back('{6, 0,0,0,0,1,0, 3});
    tab.push_back('{7, 0,0,0,0,1,0, 3});
    tab.push_back('{8, 0,1,0,0,1,1, 3});
    tab.push_back('{12,0,1,0,0,1,1, 7});
    tab.push_back('{13,0,1,0,0,1,0,-1});
    tab.push_back('{14,0,0,1,0,1,0,-1});
    tab.push_back('{15,1,0,0,0,1,0,-1});
    tab.push_back('{47,0,0,1,1,1,0,-1});
    tab.push_back('{48,0,0,0,0,0,0,-1});
    check_tab("stall");
    chk("stall row0 valids", $countones(cap_vld & pmask(0, 15, 1, 1)), 8);
    chk("stall total valids", $countones(cap_vld), 32);
    chk("stall regce_low", ~cap_rce & pmask(0, 48, 1, 1), pmask(5, 3, 1, 1));
    chk("stall done_mask", cap_dn, pmask(47, 1, 1, 1));

    // start held high: one IDLE cycle between runs
    do_reset();
    run_cap(50, 100, 99, 1'b1, -1, -1);
    chk("hold done44", cap_dn[44], 1);
    chk("hold idle45 busy", cap_busy[45], 0);
    chk("hold clr46", cap_clr[46], 1);
    chk("hold vld48", cap_vld[48], 1);

    // async reset mid-run, then clean restart
    do_reset();
    run_cap(30, 100, 99, 1'b0, -1, 17);
    chk("rst no_done", cap_dn, 0);
    chk("rst busy_after", cap_busy & ~pmask(0, 18, 1, 1), 0);
    do_reset();
    run_cap(NCAP, 100, 99, 1'b0, -1, -1);
    check_nominal("restart");

    // RD_LAT=2 with a 2-cycle FETCH stall
    do_reset();
    run_cap(NCAP, 5, 6, 1'b0, -1, -1);
    chk("rl2 vld_mask", bc_vld, pmask(4, 1, 1, 1) | pmask(7, 7, 1, 1) | pmask(18, 8, 12, 3));
    chk("rl2 p2_mask", bc_p2, pmask(14, 1, 1, 1) | pmask(26, 1, 12, 3));
    chk("rl2 done_mask", bc_dn, pmask(50, 1, 1, 1));
    chk("rl2 regce_low", ~bc_rce, pmask(5, 2, 1, 1));

    // stall during the last row's DRAIN
    do_reset();
    run_cap(NCAP, 43, 44, 1'b0, -1, -1);
    chk("drain vld42..45", {cap_vld[42], cap_vld[43], cap_vld[44], cap_vld[45]}, 4'b1001);
    chk("drain regce43", cap_rce[43], 0);
    chk("drain busy45", cap_busy[45], 1);
    chk("drain p2_done46", {cap_p2[46], cap_dn[46]}, 2'b11);
    chk("drain done_mask", cap_dn, pmask(46, 1, 1, 1));
    chk("drain total valids", $countones(cap_vld), 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
